// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like request arbiter.
//   state_t   : arbiter FSM states
//   ID_*      : bridge transaction owner encoding
//   SIZE_*    : sram-like access size encoding
package sram_like_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_like_strb_gen.sv
// Byte-strobe generator for a 32-bit data path.
//   size     in  access size (byte/half/word; 3 is illegal)
//   addr_lo  in  low two byte-address bits
//   wstrb    out byte enables for the addressed lanes
//   misalign out access is unaligned for its size, or size is illegal
module sram_like_strb_gen
    import sram_like_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb,
    output logic       misalign
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        wstrb    = 4'b0000;
        misalign = 1'b0;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            SIZE_WORD: begin
                wstrb    = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                // Illegal size: still issue a full-word access, but flag it.
                wstrb    = 4'b1111;
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-port sram-like to valid/ready arbiter in front of the AXI bridge.
// Data (LSU) port has fixed priority over instruction fetch; one request
// outstanding at a time.
//   aclk, areset            clock, async active-high reset
//   inst_* / data_*         sram-like request ports (req/wr/size/addr/wdata in,
//                           addr_ok/data_ok/rdata out)
//   req_*                   request channel to the bridge (valid/ready)
//   rsp_*                   response channel from the bridge (valid/ready)
//   err                     sticky: misaligned/illegal size or stray response id
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_id,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,

    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic              rsp_id,
    input  logic [DATA_W-1:0] rsp_rdata,

    output logic              err
);

    state_t            state;

    // Latched request; the bridge only ever sees these registers.
    logic              lat_id;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_wstrb;

    // Grant mux: data wins whenever it requests.
    logic              grant_any;
    logic              sel_id;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_strb;
    logic              sel_misalign;
    logic              rsp_match;

    assign grant_any = data_req | inst_req;
    assign sel_id    = data_req ? ID_DATA    : ID_INST;
    assign sel_wr    = data_req ? data_wr    : inst_wr;
    assign sel_size  = data_req ? data_size  : inst_size;
    assign sel_addr  = data_req ? data_addr  : inst_addr;
    assign sel_wdata = data_req ? data_wdata : inst_wdata;

    sram_like_strb_gen u_strb_gen (
        .size     (sel_size),
        .addr_lo  (sel_addr[1:0]),
        .wstrb    (sel_strb),
        .misalign (sel_misalign)
    );

    // Acceptance is only possible in IDLE, so it can never coincide with the
    // response cycle of the previous transaction.
    assign data_addr_ok = (state == IDLE) & data_req;
    assign inst_addr_ok = (state == IDLE) & inst_req & ~data_req;

    assign req_valid = (state == ISSUE);
    assign req_id    = lat_id;
    assign req_wr    = lat_wr;
    assign req_addr  = lat_addr;
    assign req_wdata = lat_wdata;
    assign req_wstrb = lat_wstrb;

    // rsp_ready is low outside WAIT, so late responses after reset are ignored.
    assign rsp_ready = (state == WAIT);
    assign rsp_match = rsp_ready & rsp_valid & (rsp_id == lat_id);

    assign data_data_ok = rsp_match & (lat_id == ID_DATA);
    assign inst_data_ok = rsp_match & (lat_id == ID_INST);
    assign data_rdata   = data_data_ok ? rsp_rdata : '0;
    assign inst_rdata   = inst_data_ok ? rsp_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            // NOTE: all latched request fields are reset, not only the FSM, so
            // the bridge-facing buses never carry X after reset.
            state     <= IDLE;
            lat_id    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        lat_id    <= sel_id;
                        lat_wr    <= sel_wr;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        // Strobes only mean something for writes.
                        lat_wstrb <= sel_wr ? sel_strb : 4'b0000;
                        if (sel_misalign) begin
                            err <= 1'b1;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (rsp_id == lat_id) begin
                            state <= IDLE;
                        end else begin
                            // Response for someone else: swallow it and flag.
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Sits directly upstream of the core's AXI read/write bridge.
- Accepts two sram-like request ports from the pipeline: instruction fetch and data memory (LSU).
- Arbitrates with data priority and keeps at most one request outstanding.
- Presents one valid/ready request channel to the bridge, with byte strobes generated from size and address, and routes the bridge's response back to the originating port as a one-cycle data_ok.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; fixed 32 in this revision (strobe logic assumes 4 bytes)

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- inst_req  in  1  instruction port request
- inst_wr  in  1  instruction port write (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  ADDR_W  byte address
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response for the inst port this cycle
- inst_rdata  out  DATA_W  read data, valid with inst_data_ok
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as the inst_* ports, for the LSU
- req_valid  out  1  request to bridge valid
- req_ready  in  1  bridge accepts request
- req_id  out  1  0=inst, 1=data
- req_wr  out  1  1=write
- req_addr  out  ADDR_W  byte address, passed unmodified
- req_wdata  out  DATA_W  write data
- req_wstrb  out  4  byte enables, writes only (0 on reads)
- rsp_valid  in  1  bridge response valid (read data or write ack)
- rsp_ready  out  1  arbiter accepts response
- rsp_id  in  1  response owner
- rsp_rdata  in  DATA_W  read data
- err  out  1  sticky error flag

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (async, areset=1) forces:
  - state=IDLE
  - all latched request registers=0
  - err=0
  - req_valid=0, rsp_ready=0, all addr_ok/data_ok=0
  - any outstanding transaction is dropped.
- IDLE:
  - grant = data_req ? data : (inst_req ? inst : none).
  - x_addr_ok = (state==IDLE) & granted, combinational, same cycle as req.
  - On that edge: latch id, wr, size, addr, wdata and the computed wstrb; go to ISSUE.
  - If inst_req and data_req are both high, only data_addr_ok asserts; inst waits with inst_addr_ok=0 and must hold its request. No fairness: inst may starve while data keeps requesting.
- ISSUE:
  - req_valid=1, driven from latched registers only; all fields stable while req_valid & ~req_ready.
  - req_ready=1 -> go to WAIT next edge.
- WAIT:
  - rsp_ready=1.
  - rsp_valid & rsp_id==latched id: the owner port's x_data_ok=1 (combinational) and x_rdata=rsp_rdata; go to IDLE next edge.
  - Writes also wait for rsp_valid (write ack); rdata is don't-care for writes.
  - rsp_valid with mismatched rsp_id: consumed (rsp_ready=1), err<=1, stay in WAIT.
- x_rdata outside data_ok: 0.
- Latency:
  - addr_ok at cycle T, req_valid from T+1.
  - Minimum data_ok at T+2 (req_ready at T+1, rsp_valid at T+2).
  - Earliest next addr_ok is T+3.
- Strobe and alignment (sub-module):
  - size 0: wstrb = 4'b0001 << addr[1:0].
  - size 1: wstrb = addr[1] ? 4'b1100 : 4'b0011; if addr[0]=1, err<=1.
  - size 2: wstrb = 4'b1111; if addr[1:0]!=0, err<=1.
  - size 3: wstrb = 4'b1111, err<=1.
  - The request is still issued in every error case; err clears only on reset.
- Simultaneous events: a new req arriving while in WAIT gets no addr_ok. The response cycle and the new acceptance never overlap, because addr_ok requires state==IDLE.
- Reset mid-operation: a late rsp_valid after reset is ignored, because rsp_ready=0 in IDLE.

Decomposition:
- Package sram_like_pkg:
  - state enum {IDLE, ISSUE, WAIT}
  - ID_INST=0, ID_DATA=1
  - SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2
- Sub-module sram_like_strb_gen: combinational; inputs size and addr[1:0]; outputs wstrb[3:0] and misalign.
- FSM, latch registers and response routing stay in the top module.

Test Plan:
- Data read: data_req, size=2, addr=0x1000_0004; req_ready=1 at T+1; rsp_valid, id=1, rdata=0xDEADBEEF at T+2 -> data_addr_ok at T, req_id=1, req_wstrb=0, data_data_ok at T+2 with data_rdata=0xDEADBEEF, inst_data_ok=0.
- Conflict: inst_req and data_req together in IDLE -> data_addr_ok=1, inst_addr_ok=0. After the data response, inst_addr_ok=1 the next cycle, and req_id=0 follows.
- Byte/half writes:
  - data_wr, size=0, addr=...03, wdata=0xAB -> req_wstrb=4'b1000, err=0.
  - size=1, addr=...02 -> 4'b1100.
  - size=1, addr=...01 -> err=1 sticky, request still issued.
- Backpressure: hold req_ready=0 for 5 cycles -> req_valid stays 1 with req_addr, req_wdata, req_wstrb unchanged, no second addr_ok; req_ready=1 moves the FSM to WAIT.
- Wrong id: in WAIT with latched id=0, rsp_valid with rsp_id=1 -> no data_ok, err=1. A following rsp with id=0 gives inst_data_ok=1.
- Reset mid-op: assert areset in WAIT -> req_valid, rsp_ready, data_ok, err all 0 immediately. After release, a stray rsp_valid produces no data_ok and the next request is accepted normally.
